// File: rtl/hangman_engine.sv
// hangman_engine: parametrised hangman core.
// One game at a time. A guess is accepted on a valid/ready handshake. The
// word is scanned one letter per cycle, and every matching position is
// revealed in a single resolve cycle. A letter guessed a second time is
// reported as a duplicate and costs no miss. The word is either forced by
// word_sel or picked by a free-running LFSR.
module hangman_engine #(
    parameter int WORD_LEN   = 5,
    parameter int CHAR_W     = 5,
    parameter int MAX_MISSES = 7,
    parameter int NUM_WORDS  = 4,
    // word i sits at [i*WORD_LEN*CHAR_W +: WORD_LEN*CHAR_W]; letter 0 is the MSB slice
    parameter logic [NUM_WORDS*WORD_LEN*CHAR_W-1:0] WORDS = {
        5'd1,  5'd11, 5'd0,  5'd18, 5'd19,   // word3 BLAST
        5'd3,  5'd14, 5'd12, 5'd4,  5'd18,   // word2 DOMES
        5'd4,  5'd4,  5'd17, 5'd8,  5'd4,    // word1 EERIE
        5'd13, 5'd14, 5'd19, 5'd17, 5'd5     // word0 NOTRF
    },
    localparam int SEL_W  = $clog2(NUM_WORDS),
    localparam int MISS_W = $clog2(MAX_MISSES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                word_sel_en,
    input  logic [SEL_W-1:0]    word_sel,
    input  logic                guess_valid,
    input  logic [CHAR_W-1:0]   guess_char,
    output logic                guess_ready,
    output logic [WORD_LEN-1:0] revealed,
    output logic [MISS_W-1:0]   misses,
    output logic                hit,
    output logic                miss,
    output logic                dup,
    output logic                win,
    output logic                lose,
    output logic                busy
);

    localparam int WORD_BITS = WORD_LEN * CHAR_W;
    localparam int POS_W     = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam int MAP_N     = 2 ** CHAR_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_RESOLVE = 3'd4;
    localparam logic [2:0] S_WIN     = 3'd5;
    localparam logic [2:0] S_LOSE    = 3'd6;

    logic [2:0]          state_q,    state_d;
    logic [7:0]          lfsr_q,     lfsr_d;
    logic [SEL_W-1:0]    sel_q,      sel_d;
    logic [WORD_BITS-1:0] word_q,    word_d;
    logic [WORD_LEN-1:0] revealed_q, revealed_d;
    logic [MISS_W-1:0]   misses_q,   misses_d;
    logic                win_q,      win_d;
    logic                lose_q,     lose_d;
    logic [MAP_N-1:0]    bitmap_q,   bitmap_d;
    logic [CHAR_W-1:0]   guess_q,    guess_d;
    logic                dup_flag_q, dup_flag_d;
    logic [WORD_LEN-1:0] match_q,    match_d;
    logic [POS_W-1:0]    pos_q,      pos_d;

    logic [WORD_BITS-1:0] word_tab [NUM_WORDS];
    logic [WORD_LEN-1:0]  letter_eq;
    logic [WORD_LEN-1:0]  pos_sel;
    logic [WORD_LEN-1:0]  rev_merge;
    logic                 lfsr_fb;

    // Unpack the flat word table into one entry per word
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_tab
        assign word_tab[gi] = WORDS[gi*WORD_BITS +: WORD_BITS];
    end

    // Per-position compare. Mask bit j belongs to letter WORD_LEN-1-j, so
    // position k of the scan lands in bit WORD_LEN-1-k.
    for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_pos
        assign letter_eq[gi] = (word_q[gi*CHAR_W +: CHAR_W] == guess_q);
        assign pos_sel[gi]   = (pos_q == POS_W'(WORD_LEN - 1 - gi));
    end

    // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register
    assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign rev_merge = revealed_q | match_q;

    // Next-state logic for the game FSM and all datapath registers
    always_comb begin
        state_d    = state_q;
        lfsr_d     = {lfsr_q[6:0], lfsr_fb};
        sel_d      = sel_q;
        word_d     = word_q;
        revealed_d = revealed_q;
        misses_d   = misses_q;
        win_d      = win_q;
        lose_d     = lose_q;
        bitmap_d   = bitmap_q;
        guess_d    = guess_q;
        dup_flag_d = dup_flag_q;
        match_d    = match_q;
        pos_d      = pos_q;

        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                // The word index is captured in the start cycle; the table
                // read happens in LOAD.
                if (start) begin
                    sel_d   = word_sel_en ? word_sel : lfsr_q[SEL_W-1:0];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                word_d     = word_tab[sel_q];
                revealed_d = '0;
                misses_d   = '0;
                bitmap_d   = '0;
                win_d      = 1'b0;
                lose_d     = 1'b0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (guess_valid) begin
                    guess_d              = guess_char;
                    dup_flag_d           = bitmap_q[guess_char];
                    bitmap_d[guess_char] = 1'b1;
                    match_d              = '0;
                    pos_d                = '0;
                    state_d              = S_CHECK;
                end
            end
            S_CHECK: begin
                match_d = match_q | (letter_eq & pos_sel);
                if (pos_q == POS_W'(WORD_LEN - 1)) begin
                    state_d = S_RESOLVE;
                end else begin
                    pos_d = pos_q + POS_W'(1);
                end
            end
            S_RESOLVE: begin
                if (dup_flag_q) begin
                    // Repeat guesses never change the board, hit or not
                    state_d = S_WAIT;
                end else if (|match_q) begin
                    revealed_d = rev_merge;
                    if (&rev_merge) begin
                        win_d   = 1'b1;
                        state_d = S_WIN;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    // Saturate at the limit; reaching it ends the game
                    if (misses_q >= MISS_W'(MAX_MISSES - 1)) begin
                        misses_d = MISS_W'(MAX_MISSES);
                        lose_d   = 1'b1;
                        state_d  = S_LOSE;
                    end else begin
                        misses_d = misses_q + MISS_W'(1);
                        state_d  = S_WAIT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset wins over every state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lfsr_q     <= 8'h01;
            sel_q      <= '0;
            word_q     <= '0;
            revealed_q <= '0;
            misses_q   <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            bitmap_q   <= '0;
            guess_q    <= '0;
            dup_flag_q <= 1'b0;
            match_q    <= '0;
            pos_q      <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            sel_q      <= sel_d;
            word_q     <= word_d;
            revealed_q <= revealed_d;
            misses_q   <= misses_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            bitmap_q   <= bitmap_d;
            guess_q    <= guess_d;
            dup_flag_q <= dup_flag_d;
            match_q    <= match_d;
            pos_q      <= pos_d;
        end
    end

    // Result pulses are decoded from registered state, so each one lasts
    // exactly the single RESOLVE cycle and at most one is ever high.
    assign hit  = (state_q == S_RESOLVE) & ~dup_flag_q & (|match_q);
    assign miss = (state_q == S_RESOLVE) & ~dup_flag_q & ~(|match_q);
    assign dup  = (state_q == S_RESOLVE) & dup_flag_q;

    assign guess_ready = (state_q == S_WAIT);
    assign busy        = (state_q == S_LOAD) | (state_q == S_CHECK) | (state_q == S_RESOLVE);
    assign revealed    = revealed_q;
    assign misses      = misses_q;
    assign win         = win_q;
    assign lose        = lose_q;

endmodule
